// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Bridges the execute stage and a word-addressed data memory. Byte-addressed
// RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) become 32-bit memory word
// reads and writes. Sub-word stores use a read-modify-write sequence. Load data
// is aligned and sign/zero extended. Misaligned, illegal-funct3 and
// out-of-range accesses return an error response without touching memory.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   req_valid    core presents a request
//   req_ready    unit can accept a request (high only in IDLE)
//   req_we       1 = store, 0 = load
//   req_funct3   RV32I funct3 size/sign code
//   req_addr     byte address
//   req_wdata    store data, right-aligned
//   resp_valid   response available, held until resp_ready
//   resp_ready   core accepts the response
//   resp_rdata   extended load data; 0 for stores and errors
//   resp_err     misaligned, illegal funct3 or out-of-range access
//   mem_addr     word index (req_addr >> 2), 0 when no access is in flight
//   mem_rd_en    memory read enable
//   mem_rd_data  combinational read data from memory
//   mem_wr_en    memory write enable; memory writes on the clk edge
//   mem_wr_data  full word written to memory
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int DEPTH_WORDS = 32,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  // Word-index limit at the width of the word-index field of the address.
  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);

  state_t state;
  state_t state_next;

  // Captured request and datapath registers.
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  // Accept-time decode.
  logic accept;
  logic legal_f3;
  logic misaligned;
  logic out_of_range;
  logic acc_err;

  // Load alignment / store merge.
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // Request classification, evaluated on the live request in IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    legal_f3     = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;

    if (req_we) begin
      legal_f3 = req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      legal_f3 = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end

    // funct3[1:0] encodes the access size: 00 byte, 01 halfword, 10 word.
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    out_of_range = (req_addr[ADDR_W-1:2] >= DEPTH_LIM);
  end

  assign acc_err = !legal_f3 || misaligned || out_of_range;

  // ---------------------------------------------------------------------------
  // FSM: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (acc_err) begin
            state_next = RESP;
          end else if (!req_we) begin
            state_next = LOAD;
          end else if (req_funct3[1:0] == 2'b10) begin
            state_next = WRITE;
          end else begin
            state_next = RMW_RD;
          end
        end
      end
      LOAD:    state_next = RESP;
      RMW_RD:  state_next = WRITE;
      WRITE:   state_next = RESP;
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= acc_err;
            // Stores and errors respond with zero data.
            rdata_q  <= 32'h0;
          end
        end
        LOAD:    rdata_q <= load_data;
        RMW_RD:  merge_q <= mem_rd_data;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load alignment and extension from the word being read.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_byte = 8'h00;
    load_half = 16'h0000;
    load_data = 32'h0;

    unique case (addr_q[1:0])
      2'd0: load_byte = mem_rd_data[7:0];
      2'd1: load_byte = mem_rd_data[15:8];
      2'd2: load_byte = mem_rd_data[23:16];
      2'd3: load_byte = mem_rd_data[31:24];
    endcase

    load_half = addr_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];

    unique case (funct3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'h0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'h0, load_half};
      default: load_data = mem_rd_data;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store word: full word for SW, lane-merged captured word for SB/SH.
  // ---------------------------------------------------------------------------
  always_comb begin
    store_word = merge_q;
    unique case (funct3_q[1:0])
      2'b00: begin
        unique case (addr_q[1:0])
          2'd0: store_word[7:0]   = wdata_q[7:0];
          2'd1: store_word[15:8]  = wdata_q[7:0];
          2'd2: store_word[23:16] = wdata_q[7:0];
          2'd3: store_word[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) begin
          store_word[31:16] = wdata_q[15:0];
        end else begin
          store_word[15:0]  = wdata_q[15:0];
        end
      end
      default: store_word = wdata_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. All are decoded from the state register, so the asynchronous
  // reset forces them (mem_wr_en in particular) low without waiting for an
  // edge.
  // ---------------------------------------------------------------------------
  assign mem_rd_en   = (state == LOAD) || (state == RMW_RD);
  assign mem_wr_en   = (state == WRITE);
  assign mem_wr_data = mem_wr_en ? store_word : 32'h0;
  assign mem_addr    = (mem_rd_en || mem_wr_en) ? {2'b00, addr_q[ADDR_W-1:2]} : '0;

  assign resp_valid  = (state == RESP);
  assign resp_err    = resp_valid && err_q;
  assign resp_rdata  = resp_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. A word memory is attached to the
// memory port. A transaction-level reference model predicts, from the access
// rules, each request's latency, memory pulses, written word and response;
// a compare process checks every DUT output against it on every falling edge.
// Directed sequences pin the model with hand-computed values, followed by
// randomized traffic and a final memory comparison.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Attached memory (environment) with a preload port shared with the model.
  // ---------------------------------------------------------------------------
  logic [31:0] env_mem [DEPTH];
  logic        pl_en  = 1'b0;
  int          pl_idx = 0;
  logic [31:0] pl_val = 32'h0;

  assign mem_rd_data = (mem_addr < DEPTH) ? env_mem[mem_addr[4:0]] : 32'h0;

  always @(posedge clk) begin
    if (pl_en) begin
      env_mem[pl_idx] <= pl_val;
    end else if (mem_wr_en && (mem_addr < DEPTH)) begin
      env_mem[mem_addr[4:0]] <= mem_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: one transaction at a time. k counts cycles since accept
  // (k=1 is the cycle right after the accept edge); the response appears at
  // k >= m_lat.
  // ---------------------------------------------------------------------------
  logic [31:0] ref_mem [DEPTH];
  bit          busy = 1'b0;
  int          k = 0;
  int          m_lat = 0;
  bit          m_rd = 1'b0;
  bit          m_st = 1'b0;
  logic [31:0] m_idx = 32'h0;
  logic [31:0] m_wr = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  bit          m_err = 1'b0;

  task automatic model_accept(input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] mask;
    int          bsh;
    int          hsh;
    bit          legal;
    bit          misal;
    bit          oob;
    m_idx   = a >> 2;
    bsh     = 8 * int'(a[1:0]);
    hsh     = 16 * int'(a[1]);
    legal   = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misal   = ((f3[1:0] == 2'd1) && a[0]) || ((f3[1:0] == 2'd2) && (a[1:0] != 2'd0));
    oob     = (m_idx >= DEPTH);
    m_err   = !legal || misal || oob;
    m_rd    = 1'b0;
    m_st    = 1'b0;
    m_wr    = 32'h0;
    m_rdata = 32'h0;
    if (m_err) begin
      m_lat = 1;
    end else if (!we) begin
      m_lat = 2;
      m_rd  = 1'b1;
      w     = ref_mem[m_idx];
      b     = (w >> bsh) & 32'hFF;
      h     = (w >> hsh) & 32'hFFFF;
      case (f3)
        3'd0:    m_rdata = (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
        3'd4:    m_rdata = b;
        3'd1:    m_rdata = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
        3'd5:    m_rdata = h;
        default: m_rdata = w;
      endcase
    end else if (f3 == 3'd2) begin
      m_lat = 2;
      m_st  = 1'b1;
      m_wr  = wd;
    end else begin
      m_lat = 3;
      m_rd  = 1'b1;
      m_st  = 1'b1;
      w     = ref_mem[m_idx];
      if (f3 == 3'd0) begin
        mask = 32'hFF << bsh;
        m_wr = (w & ~mask) | ((wd & 32'hFF) << bsh);
      end else begin
        mask = 32'hFFFF << hsh;
        m_wr = (w & ~mask) | ((wd & 32'hFFFF) << hsh);
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy = 1'b0;
    end else begin
      if (pl_en) ref_mem[pl_idx] = pl_val;
      if (busy) begin
        if (k >= m_lat) begin
          if (resp_ready) busy = 1'b0;
        end else begin
          // The word is written by the edge that ends the write cycle.
          if (m_st && (k == m_lat - 1)) ref_mem[m_idx] = m_wr;
          k++;
        end
      end else if (req_valid) begin
        model_accept(req_we, req_funct3, req_addr, req_wdata);
        busy = 1'b1;
        k    = 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: every falling edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    bit exp_valid;
    bit exp_rd;
    bit exp_wr;
    if (!reset) begin
      check("rst_req_ready",   req_ready,   1);
      check("rst_resp_valid",  resp_valid,  0);
      check("rst_resp_err",    resp_err,    0);
      check("rst_resp_rdata",  resp_rdata,  0);
      check("rst_mem_rd_en",   mem_rd_en,   0);
      check("rst_mem_wr_en",   mem_wr_en,   0);
      check("rst_mem_addr",    mem_addr,    0);
      check("rst_mem_wr_data", mem_wr_data, 0);
    end else begin
      exp_valid = busy && (k >= m_lat);
      exp_rd    = busy && m_rd && (k == 1);
      exp_wr    = busy && m_st && (k == m_lat - 1);
      check("req_ready",  req_ready,  !busy);
      check("resp_valid", resp_valid, exp_valid);
      check("mem_rd_en",  mem_rd_en,  exp_rd);
      check("mem_wr_en",  mem_wr_en,  exp_wr);
      if (exp_valid) begin
        check("resp_rdata", resp_rdata, m_rdata);
        check("resp_err",   resp_err,   m_err);
      end
      if (exp_rd || exp_wr) check("mem_addr", mem_addr, m_idx);
      if (exp_wr) check("mem_wr_data", mem_wr_data, m_wr);
      if (!busy) check("mem_addr_idle", mem_addr, 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called and returning on a falling edge).
  // ---------------------------------------------------------------------------
  task automatic preload(input int idx, input logic [31:0] val);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int bp,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", req_ready, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    lat = 1;
    // Junk on the request port while busy must be ignored.
    req_valid  = 1'($urandom);
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("resp_timeout", resp_valid, 1);
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
    end
    req_valid  = 1'b0;
    rdata      = resp_rdata;
    err        = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus.
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;

    reset      = 1'b0;
    resp_ready = 1'b0;
    // A request held during reset must not be accepted.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h4;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    check("post_rst_ready", req_ready,  1);
    check("post_rst_valid", resp_valid, 0);
    check("post_rst_wr_en", mem_wr_en,  0);

    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);

    // Loads from word 1 = 0x8081_82F3.
    preload(1, 32'h8081_82F3);
    do_req(1'b0, 3'b000, 32'h6, 32'h0, 0, rd, er, lat);
    check("lb_rdata", rd, 32'hFFFF_FF81);
    check("lb_lat",   lat, 2);
    do_req(1'b0, 3'b100, 32'h6, 32'h0, 0, rd, er, lat);
    check("lbu_rdata", rd, 32'h0000_0081);
    do_req(1'b0, 3'b101, 32'h6, 32'h0, 0, rd, er, lat);
    check("lhu_rdata", rd, 32'h0000_8081);
    do_req(1'b0, 3'b001, 32'h6, 32'h0, 0, rd, er, lat);
    check("lh_rdata", rd, 32'hFFFF_8081);
    do_req(1'b0, 3'b010, 32'h4, 32'h0, 0, rd, er, lat);
    check("lw_rdata", rd, 32'h8081_82F3);

    // SB read-modify-write into word 2 = 0x1122_3344.
    preload(2, 32'h1122_3344);
    do_req(1'b1, 3'b000, 32'h9, 32'h0000_00AA, 0, rd, er, lat);
    check("sb_lat",   lat, 3);
    check("sb_rdata", rd, 32'h0);
    check("sb_mem",   env_mem[2], 32'h1122_AA44);
    do_req(1'b0, 3'b010, 32'h8, 32'h0, 0, rd, er, lat);
    check("sb_lw_back", rd, 32'h1122_AA44);
    do_req(1'b1, 3'b001, 32'hA, 32'hDEAD_BEEF, 0, rd, er, lat);
    check("sh_lat", lat, 3);
    check("sh_mem", env_mem[2], 32'hBEEF_AA44);
    do_req(1'b1, 3'b010, 32'h8, 32'h0BAD_CAFE, 0, rd, er, lat);
    check("sw_lat", lat, 2);
    check("sw_mem", env_mem[2], 32'h0BAD_CAFE);

    // Error cases: one cycle to response, zero data, no memory pulses.
    do_req(1'b0, 3'b010, 32'h5, 32'h0, 0, rd, er, lat);
    check("err_lw_mis_err", er, 1);
    check("err_lw_mis_lat", lat, 1);
    check("err_lw_mis_rd",  rd, 0);
    do_req(1'b1, 3'b001, 32'h3, 32'h1234, 0, rd, er, lat);
    check("err_sh_mis_err", er, 1);
    check("err_sh_mis_lat", lat, 1);
    do_req(1'b0, 3'b011, 32'h0, 32'h0, 0, rd, er, lat);
    check("err_f3_err", er, 1);
    check("err_f3_rd",  rd, 0);
    do_req(1'b1, 3'b010, 32'h80, 32'h5555_5555, 0, rd, er, lat);
    check("err_oob_err", er, 1);
    check("err_oob_lat", lat, 1);
    do_req(1'b0, 3'b010, 32'h7C, 32'h0, 0, rd, er, lat);
    check("last_word_err", er, 0);

    // Backpressure on an LW.
    do_req(1'b0, 3'b010, 32'h4, 32'h0, 5, rd, er, lat);
    check("bp_rdata", rd, 32'h8081_82F3);
    check("bp_idle",  req_ready, 1);

    // Reset during WRITE: the target word must remain unchanged.
    preload(3, 32'hCAFE_F00D);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'hC;
    req_wdata  = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_wr_en && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("rstw_saw_write", mem_wr_en, 1);
    #2 reset = 1'b0;
    #1 check("rstw_wr_drop", mem_wr_en, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstw_idle", req_ready, 1);
    check("rstw_mem",  env_mem[3], 32'hCAFE_F00D);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        f3 = 3'($urandom);
      end else if (we) begin
        f3 = 3'($urandom_range(0, 2));
      end else begin
        case ($urandom_range(0, 4))
          0:       f3 = 3'd0;
          1:       f3 = 3'd1;
          2:       f3 = 3'd2;
          3:       f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(32, 40)) * 4 + 32'($urandom_range(0, 3));
        default: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      endcase
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
      else if (f3[1:0] == 2'd1) a[1] = 1'($urandom);
      else if (f3[1:0] == 2'd0) a[1:0] = 2'($urandom);
      do_req(we, f3, a, $urandom, $urandom_range(0, 3), rd, er, lat);
    end

    for (int i = 0; i < DEPTH; i++) check("final_mem", env_mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
